bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// Latency: WIDTH cycles from the accepting edge to the single-cycle done pulse.
// Backpressure: none; start is honoured only while idle, and a start seen while busy is dropped.
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  // 10^DIGITS < 16^DIGITS, so one bit above the wider operand always holds the limit.
  localparam int CMPW = ((WIDTH > BW) ? WIDTH : BW) + 1;

  function automatic logic [CMPW-1:0] pow10(input int n);
    logic [CMPW-1:0] p;
    p = CMPW'(1);
    for (int i = 0; i < n; i++) begin
      p = (p << 3) + (p << 1);
    end
    return p;
  endfunction

  localparam logic [CMPW-1:0] LIMIT = pow10(DIGITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [WIDTH-1:0]     sr;
  logic [BW-1:0]        scr;
  logic [CW-1:0]        cnt;
  logic                 ovf_pend;

  logic [BW-1:0]        scr_adj;
  logic [BW+WIDTH-1:0]  cat;
  logic [BW-1:0]        scr_next;
  logic [WIDTH-1:0]     sr_next;
  logic                 ovf_in;

  // Per-digit add-3 with no cross-digit carry; the top digit's shift-out is dropped.
  always_comb begin
    scr_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      scr_adj[4*k +: 4] = (scr[4*k +: 4] >= 4'd5) ? scr[4*k +: 4] + 4'd3 : scr[4*k +: 4];
    end
  end

  assign cat      = {scr_adj, sr} << 1;
  assign scr_next = cat[BW+WIDTH-1 -: BW];
  assign sr_next  = cat[WIDTH-1:0];
  assign ovf_in   = ({{(CMPW-WIDTH){1'b0}}, bin} >= LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      scr      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr       <= bin;
            scr      <= '0;
            cnt      <= CW'(WIDTH);
            ovf_pend <= ovf_in;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scr <= scr_next;
          sr  <= sr_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= scr_next;
            ovf   <= ovf_pend;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboarded bench for bin2bcd_seq: stimulus pushes expected {bcd,ovf}, a negedge monitor pops on done.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_q[$];
  logic [15:0] last_bcd;
  logic        last_ovf;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [16:0] e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual bcd=%0h ovf=%0b required=no done", bcd, ovf);
      end else begin
        e = exp_q.pop_front();
        check("result_bcd_ovf", {15'd0, bcd, ovf}, {15'd0, e});
      end
    end
  end

  // Issue one conversion; optionally pulse a stray start while busy at iteration poke_at.
  task automatic convert(input logic [13:0] b, input logic [15:0] eb, input logic eo, input int poke_at);
    int lat      = 0;
    int busy_cnt = 0;
    bit hold_ok  = 1'b1;
    bit seen     = 1'b0;
    bin   = b;
    start = 1'b1;
    exp_q.push_back({eb, eo});
    tick();
    start = 1'b0;
    bin   = ~b;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    for (int n = 1; n <= 40 && !seen; n++) begin
      if (busy === 1'b1) busy_cnt++;
      if (bcd !== last_bcd || ovf !== last_ovf) hold_ok = 1'b0;
      if (n == poke_at) begin
        start = 1'b1;
        bin   = 14'd777;
      end
      tick();
      if (n == poke_at) start = 1'b0;
      lat = n;
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", lat, 32'd14);
    check("busy_cycles", busy_cnt, 32'd14);
    check("outputs_held_during_run", {31'd0, hold_ok}, 32'd1);
    check("busy_low_in_done_cycle", {31'd0, busy}, 32'd0);
    last_bcd = eb;
    last_ovf = eo;
  endtask

  task automatic idle_expect_quiet(input int cycles, input string name);
    int busy_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
    end
    check(name, busy_seen, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    bin      = '0;
    last_bcd = '0;
    last_ovf = 1'b0;
    repeat (3) tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd",  {16'd0, bcd},  32'd0);
    check("reset_ovf",  {31'd0, ovf},  32'd0);
    rst = 1'b0;
    tick();

    // rst and start together: reset wins, nothing captured.
    rst   = 1'b1;
    start = 1'b1;
    bin   = 14'd123;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_beats_start_busy", {31'd0, busy}, 32'd0);
    idle_expect_quiet(3, "rst_beats_start_quiet");

    convert(14'd0,     16'h0000, 1'b0, 0);
    idle_expect_quiet(2, "idle_after_zero");
    convert(14'd9999,  16'h9999, 1'b0, 0);
    idle_expect_quiet(2, "idle_after_9999");
    convert(14'd16383, 16'h6383, 1'b1, 0);
    idle_expect_quiet(2, "idle_after_16383");
    convert(14'd10000, 16'h0000, 1'b1, 0);
    idle_expect_quiet(2, "idle_after_10000");

    // Back-to-back: second start lands in the first conversion's done cycle.
    convert(14'd1234,  16'h1234, 1'b0, 0);
    convert(14'd5678,  16'h5678, 1'b0, 0);
    idle_expect_quiet(2, "idle_after_b2b");

    convert(14'd42,    16'h0042, 1'b0, 3);
    idle_expect_quiet(20, "no_second_conversion");

    // Reset mid-conversion: no done, outputs cleared.
    bin   = 14'd8765;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = '0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_reset_busy", {31'd0, busy}, 32'd0);
    check("midrun_reset_done", {31'd0, done}, 32'd0);
    check("midrun_reset_bcd",  {16'd0, bcd},  32'd0);
    check("midrun_reset_ovf",  {31'd0, ovf},  32'd0);
    last_bcd = '0;
    last_ovf = 1'b0;
    idle_expect_quiet(20, "quiet_after_midrun_reset");

    convert(14'd305,   16'h0305, 1'b0, 0);
    idle_expect_quiet(3, "idle_after_305");

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
